// File: rtl/multicycle_ctrl_if.sv
// Bundle of datapath-facing signals for the multicycle controller.
// master = datapath/environment side, slave = the controller itself.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic        pc_branch;
  logic        reg_write;
  logic        reg_res;
  logic        alu_src;
  logic        mem_to_reg;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  alu_ctrl;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] retired;

  modport master (
    output instr, zero, mem_ready,
    input  ir_write, pc_write, pc_branch, reg_write, reg_res, alu_src,
           mem_to_reg, mem_read, mem_write, alu_ctrl, state, halted, retired
  );

  modport slave (
    input  instr, zero, mem_ready,
    output ir_write, pc_write, pc_branch, reg_write, reg_res, alu_src,
           mem_to_reg, mem_read, mem_write, alu_ctrl, state, halted, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional single-step gating of FETCH is enabled with `define STEP_MODE_EN.
module multicycle_ctrl (
  input logic clock,
  input logic reset,
`ifdef STEP_MODE_EN
  input logic step,
`endif
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  funct_q, funct_d;
  logic [15:0] retired_q, retired_d;
  logic        fetch_go;
  logic        unused_instr;

  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_legal, is_branch;
  logic        in_instr;
  logic        run;

  logic        ir_write, pc_write, pc_branch, reg_write;
  logic        reg_res, alu_src, mem_to_reg, mem_read, mem_write;
  logic [5:0]  alu_ctrl;

  assign unused_instr = ^bus.instr[25:6];

`ifdef STEP_MODE_EN
  logic step_q, step_d;
  always_comb begin
    step_d   = step;
    fetch_go = step & ~step_q;
  end
`else
  always_comb fetch_go = 1'b1;
`endif

  // Decode works only on the opcode/funct captured when the instruction was fetched.
  always_comb begin
    is_r      = (op_q == OP_R);
    is_addi   = (op_q == OP_ADDI);
    is_lw     = (op_q == OP_LW);
    is_sw     = (op_q == OP_SW);
    is_beq    = (op_q == OP_BEQ);
    is_bne    = (op_q == OP_BNE);
    is_branch = is_beq | is_bne;
    is_legal  = is_r | is_addi | is_lw | is_sw | is_branch;
    in_instr  = (state_q == DECODE) || (state_q == EXEC) ||
                (state_q == MEM)    || (state_q == WB);
    run       = ~reset;
  end

  // Strobes are gated by reset so they drop the moment reset rises.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_ctrl   = 6'd0;
    alu_src    = 1'b0;
    reg_res    = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      FETCH: ir_write = run & fetch_go;
      EXEC: begin
        if (is_branch) begin
          pc_write  = run;
          pc_branch = run & ((is_beq & bus.zero) | (is_bne & ~bus.zero));
        end
      end
      MEM: begin
        mem_read  = run & is_lw;
        mem_write = run & is_sw;
        pc_write  = run & is_sw & bus.mem_ready;
      end
      WB: begin
        reg_write = run;
        pc_write  = run;
      end
      default: ;
    endcase
    if (in_instr && is_legal) begin
      if (is_r)
        alu_ctrl = funct_q;
      else if (is_branch)
        alu_ctrl = 6'b100010;
      else
        alu_ctrl = 6'b100000;
      alu_src    = is_addi | is_lw | is_sw;
      reg_res    = is_r;
      mem_to_reg = is_lw;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    retired_d = retired_q + {15'd0, pc_write};
    case (state_q)
      FETCH: begin
        if (fetch_go) begin
          state_d = DECODE;
          op_d    = bus.instr[31:26];
          funct_d = bus.instr[5:0];
        end
      end
      DECODE: state_d = is_legal ? EXEC : HALT;
      EXEC: begin
        if (is_branch)
          state_d = FETCH;
        else if (is_r || is_addi)
          state_d = WB;
        else if (is_lw || is_sw)
          state_d = MEM;
        else
          state_d = HALT;
      end
      MEM: begin
        if (bus.mem_ready)
          state_d = is_lw ? WB : FETCH;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      retired_q <= 16'd0;
`ifdef STEP_MODE_EN
      step_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      retired_q <= retired_d;
`ifdef STEP_MODE_EN
      step_q    <= step_d;
`endif
    end
  end

  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_branch  = pc_branch;
  assign bus.reg_write  = reg_write;
  assign bus.reg_res    = reg_res;
  assign bus.alu_src    = alu_src;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == HALT);
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction trace model predicts every cycle's
// strobes, selects and retired count; the step scenario runs only with STEP_MODE_EN.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pcw, pcb, rw, mr, mw;
    logic [5:0] alu;
    logic       src, res, m2r;
    logic       cs;
    logic       rdy, zr;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        step_hold;
  int          checks;
  int          errors;
  logic [15:0] exp_retired;
  exp_t        exp_q[$];

`ifdef STEP_MODE_EN
  logic step;
`endif

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clock (clock),
    .reset (reset),
`ifdef STEP_MODE_EN
    .step  (step),
`endif
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [2:0] st, input logic [5:0] alu,
                              input logic src, input logic res, input logic m2r, input logic cs);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.alu = alu;
    e.src = src;
    e.res = res;
    e.m2r = m2r;
    e.cs  = cs;
    e.rdy = 1'($urandom);
    e.zr  = 1'($urandom);
    return e;
  endfunction

  // Expected cycle-by-cycle trace of one instruction, from the ISA-level rules.
  task automatic model_instr(input logic [31:0] ins, input logic zr, input int w, input int halt_cyc);
    logic [5:0] op, alu;
    logic r, addi, lw, sw, beq, bne, legal, src;
    exp_t e;
    op    = ins[31:26];
    r     = (op == 6'b000000);
    addi  = (op == 6'b001000);
    lw    = (op == 6'b100011);
    sw    = (op == 6'b101011);
    beq   = (op == 6'b000100);
    bne   = (op == 6'b000101);
    legal = r | addi | lw | sw | beq | bne;
    src   = addi | lw | sw;
    alu   = r ? ins[5:0] : src ? 6'b100000 : 6'b100010;
    e = mk(3'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.ir = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(mk(3'd1, alu, src, r, lw, legal));
    if (!legal) begin
      for (int i = 0; i < halt_cyc; i++) exp_q.push_back(mk(3'd5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      return;
    end
    e = mk(3'd2, alu, src, r, lw, 1'b1);
    if (beq || bne) begin
      e.zr  = zr;
      e.pcw = 1'b1;
      e.pcb = beq ? zr : ~zr;
      exp_q.push_back(e);
      return;
    end
    exp_q.push_back(e);
    if (lw || sw) begin
      for (int i = 0; i <= w; i++) begin
        e = mk(3'd3, alu, src, r, lw, 1'b1);
        e.mr  = lw;
        e.mw  = sw;
        e.rdy = (i == w);
        e.pcw = sw && (i == w);
        exp_q.push_back(e);
      end
      if (sw) return;
    end
    e = mk(3'd4, alu, src, r, lw, 1'b1);
    e.rw  = 1'b1;
    e.pcw = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drives one cycle per queued entry (from just after a posedge) and scores it at the negedge.
  task automatic run_trace(input logic [31:0] ins, input int max_cyc, input string name);
    exp_t e;
    logic [9:0] obs_s, exp_s;
    logic [8:0] obs_d, exp_d;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      e = exp_q.pop_front();
      bus.instr     = (e.st == 3'd0) ? ins : $urandom;
      bus.zero      = e.zr;
      bus.mem_ready = e.rdy;
`ifdef STEP_MODE_EN
      step = step_hold | (e.st == 3'd0);
`endif
      @(negedge clock);
      obs_s = {bus.state, bus.ir_write, bus.pc_write, bus.pc_branch, bus.reg_write,
               bus.mem_read, bus.mem_write, bus.halted};
      exp_s = {e.st, e.ir, e.pcw, e.pcb, e.rw, e.mr, e.mw, (e.st == 3'd5)};
      checks++;
      if (obs_s !== exp_s) begin
        errors++;
        $display("FAIL %s cycle %0d state/strobes got=%b exp=%b", name, n, obs_s, exp_s);
      end
      if (e.cs) begin
        obs_d = {bus.alu_ctrl, bus.alu_src, bus.reg_res, bus.mem_to_reg};
        exp_d = {e.alu, e.src, e.res, e.m2r};
        checks++;
        if (obs_d !== exp_d) begin
          errors++;
          $display("FAIL %s cycle %0d selects got=%b exp=%b", name, n, obs_d, exp_d);
        end
      end
      checks++;
      if (bus.retired !== exp_retired) begin
        errors++;
        $display("FAIL %s cycle %0d retired got=%0d exp=%0d", name, n, bus.retired, exp_retired);
      end
      if (e.pcw) exp_retired++;
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  // Holds reset for two edges and releases it just after a posedge, leaving a fresh FETCH cycle.
  task automatic release_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset       = 1'b0;
    exp_retired = 16'd0;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_read, bus.mem_write,
         bus.halted, bus.alu_ctrl, bus.retired} !== 31'd0) begin
      errors++;
      $display("FAIL reset_values got state=%0d ir=%b pcw=%b alu=%h ret=%0d exp all zero",
               bus.state, bus.ir_write, bus.pc_write, bus.alu_ctrl, bus.retired);
    end
    release_reset();
`ifdef STEP_MODE_EN
    step = 1'b1;
`endif
    #1;
    checks++;
    if (bus.ir_write !== 1'b1) begin
      errors++;
      $display("FAIL first_ir_write got=%b exp=1", bus.ir_write);
    end
  endtask

  task automatic test_add();
    model_instr(32'h00221820, 1'b0, 0, 0);
    run_trace(32'h00221820, 10, "add");
    checks++;
    if (bus.retired !== 16'd1) begin
      errors++;
      $display("FAIL add_retired got=%0d exp=1", bus.retired);
    end
  endtask

  task automatic test_lw();
    model_instr(32'h8C410004, 1'b0, 3, 0);
    checks++;
    if (exp_q.size() != 8) begin
      errors++;
      $display("FAIL lw_latency got=%0d exp=8", exp_q.size());
    end
    run_trace(32'h8C410004, 20, "lw");
  endtask

  task automatic test_branch();
    model_instr(32'h10220003, 1'b1, 0, 0);
    run_trace(32'h10220003, 10, "beq_taken");
    model_instr(32'h10220003, 1'b0, 0, 0);
    run_trace(32'h10220003, 10, "beq_not_taken");
    model_instr(32'h14220003, 1'b0, 0, 0);
    run_trace(32'h14220003, 10, "bne_taken");
    model_instr(32'h14220003, 1'b1, 0, 0);
    run_trace(32'h14220003, 10, "bne_not_taken");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [5:0]  ops[6];
    ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000101};
    for (int k = 0; k < 40; k++) begin
      ins        = $urandom;
      ins[31:26] = ops[$urandom_range(0, 5)];
      model_instr(ins, 1'($urandom), $urandom_range(0, 4), 0);
      run_trace(ins, 20, "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    model_instr(32'h00221820, 1'b0, 0, 0);
    run_trace(32'h00221820, 10, "add_before_sw");
    model_instr(32'hAC430008, 1'b0, 6, 0);
    run_trace(32'hAC430008, 5, "sw_wait");
    exp_q.delete();
    bus.instr     = $urandom;
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.mem_write} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL sw_mid_wait got state=%0d mw=%b exp state=3 mw=1", bus.state, bus.mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.mem_write, bus.retired, bus.halted} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_mem got state=%0d mw=%b ret=%0d halted=%b exp 0/0/0/0",
               bus.state, bus.mem_write, bus.retired, bus.halted);
    end
    release_reset();
    model_instr(32'h2022000F, 1'b0, 0, 0);
    run_trace(32'h2022000F, 10, "addi_after_reset");
  endtask

  task automatic test_illegal();
    model_instr(32'hFC000000, 1'b0, 0, 20);
    run_trace(32'hFC000000, 30, "illegal");
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.state, bus.halted} !== 4'd0) begin
      errors++;
      $display("FAIL halt_exit got state=%0d halted=%b exp 0/0", bus.state, bus.halted);
    end
    release_reset();
    model_instr(32'h00221820, 1'b0, 0, 0);
    run_trace(32'h00221820, 10, "add_after_halt");
  endtask

`ifdef STEP_MODE_EN
  task automatic test_step();
    for (int i = 0; i < 10; i++) begin
      step      = 1'b0;
      bus.instr = $urandom;
      @(negedge clock);
      checks++;
      if ({bus.state, bus.ir_write} !== 4'd0) begin
        errors++;
        $display("FAIL step_low cycle %0d got state=%0d ir=%b exp 0/0", i, bus.state, bus.ir_write);
      end
      @(posedge clock);
      #1;
    end
    step_hold = 1'b1;
    model_instr(32'h00221820, 1'b0, 0, 0);
    run_trace(32'h00221820, 10, "step_one");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.ir_write, bus.retired} !== {1'b0, exp_retired}) begin
        errors++;
        $display("FAIL step_held cycle %0d got ir=%b ret=%0d exp ir=0 ret=%0d",
                 i, bus.ir_write, bus.retired, exp_retired);
      end
      @(posedge clock);
      #1;
    end
    step_hold = 1'b0;
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    exp_retired   = 16'd0;
    step_hold     = 1'b0;
    reset         = 1'b0;
    bus.instr     = 32'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
`ifdef STEP_MODE_EN
    step          = 1'b0;
`endif
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_back_to_back();
    test_reset_mid_mem();
    test_illegal();
`ifdef STEP_MODE_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width and meaning. Clock and reset come first.
- clock  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  current instruction word: opcode [31:26], funct [5:0].
- zero  in  1  high when the ALU result equals 32'd0.
- mem_ready  in  1  data-memory completion handshake.
- step  in  1  single-step request; present only with STEP_MODE_EN.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  PC advances this cycle (sequential or branch).
- pc_branch  out  1  PC takes the offset target; valid only with pc_write.
- reg_write, reg_res, alu_src, mem_to_reg  out  1 each  datapath selects.
- mem_read, mem_write  out  1 each  data-memory strobes.
- alu_ctrl  out  6  ALU opcode.
- state  out  3  current FSM state.
- halted  out  1  high in HALT.
- retired  out  16  count of retired instructions.

Function
REQ-002 The FSM states SHALL be encoded as FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT on the next edge.
REQ-003 FETCH SHALL assert ir_write for one cycle and then go to DECODE.
REQ-004 In DECODE, legal opcodes SHALL go to EXEC. Legal opcodes are R=000000, ADDI=001000, LW=100011, SW=101011, BEQ=000100 and BNE=000101. Any other opcode SHALL go to HALT.
REQ-005 alu_ctrl SHALL be decided as follows:
- R-type: instr[5:0].
- ADDI, LW, SW: 6'b100000.
- BEQ, BNE: 6'b100010.
- alu_ctrl SHALL be held stable from DECODE through the last state of the instruction.
REQ-006 alu_src SHALL be 1 for ADDI, LW and SW, and 0 otherwise.
REQ-007 reg_res SHALL be 1 for R-type and 0 otherwise.
REQ-008 mem_to_reg SHALL be 1 for LW only.
REQ-009 EXEC SHALL go to WB for R-type and ADDI, and to MEM for LW and SW.
REQ-010 For BEQ and BNE, EXEC SHALL assert pc_write and go to FETCH. pc_branch SHALL be 1 when (BEQ and zero) or (BNE and !zero).
REQ-011 MEM SHALL hold mem_read (LW) or mem_write (SW) high every cycle until mem_ready=1. It SHALL stay in MEM while mem_ready=0.
REQ-012 When mem_ready=1 in MEM, LW SHALL go to WB. SW SHALL assert pc_write and go to FETCH.
REQ-013 WB SHALL assert reg_write and pc_write for exactly one cycle and go to FETCH.
REQ-014 Instruction latency SHALL be, counted from FETCH:
- branch: 3 cycles
- R-type and ADDI: 4 cycles
- SW: 4 + W cycles
- LW: 5 + W cycles
- W is the number of mem_ready=0 cycles in MEM.
REQ-015 retired SHALL increment by 1 on every cycle in which pc_write=1, and SHALL wrap from 16'hFFFF to 0.
REQ-016 HALT SHALL be absorbing. In HALT, halted=1 and all strobes (ir_write, pc_write, reg_write, mem_read, mem_write) SHALL be 0; only reset exits HALT.
REQ-017 Outputs SHALL be decoded from the registered state and the registered opcode/funct, giving glitch-free strobes.
REQ-018 Outside the states named above, every strobe SHALL be 0.

Reset
REQ-019 Asserting reset at any time, including mid-MEM wait, SHALL immediately force:
- state=FETCH
- retired=0
- halted=0
- all strobes=0
- alu_ctrl=0
- the step edge register=0
REQ-020 The first ir_write SHALL occur in the first cycle after reset deasserts.

Configuration
REQ-021 STEP_MODE_EN defined:
- The step port exists and the block registers it.
- FETCH SHALL assert ir_write and proceed only in a cycle where step=1 and the previous step sample was 0 (rising edge).
- Otherwise FETCH SHALL hold with ir_write=0.
- Exactly one instruction executes per rising edge of step.
REQ-022 STEP_MODE_EN undefined: there is no step port and FETCH proceeds unconditionally.

Verification
REQ-023 ADD: instr=32'h00221820 -> ir_write, then DECODE, then EXEC, then WB with reg_write=1, reg_res=1, alu_ctrl=6'b100000; retired 0->1 after 4 cycles.
REQ-024 LW: instr=32'h8C410004, mem_ready held low 3 cycles -> mem_read high 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-025 BEQ: instr=32'h10220003 with zero=1 -> pc_write=1 and pc_branch=1 in EXEC. Same with zero=0 -> pc_branch=0.
REQ-026 Illegal opcode: instr=32'hFC000000 -> HALT after DECODE, halted=1; stays halted 20 cycles with all strobes 0 until reset.
REQ-027 Reset asserted during MEM with mem_write=1 -> mem_write drops immediately, state=0, retired=0.
REQ-028 STEP_MODE_EN: step low 10 cycles -> no ir_write. One step pulse -> exactly one instruction retires. step held high -> no second instruction.
